input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage that feeds the input synchronizer of the traffic light controller.
- Takes raw push-button and switch inputs (Sensor, WalkRequest, Reprogram, spare) and synchronizes each to clk.
- Debounces each channel and publishes a clean level, single-cycle rise/fall pulses and a long-press flag.
- Downstream FSM, WalkReg and Time_Parameters logic sees only glitch-free, single-event signals.

Parameters:
- NUM_CH, 4, number of independent input channels.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a changed level must hold before acceptance (10 ms at 100 MHz); legal range ≥2.
- HOLD_CYCLES, 200000000, cycles Stable must stay high before Held asserts (2 s at 100 MHz); must be > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, single domain.
- Reset_n  in  1  asynchronous, active-low reset.
- Raw_In  in  NUM_CH  asynchronous raw inputs; bit i is channel i.
- Stable  out  NUM_CH  debounced level per channel.
- Rise  out  NUM_CH  one-cycle pulse in the first cycle Stable[i] is 1.
- Fall  out  NUM_CH  one-cycle pulse in the first cycle Stable[i] is 0.
- Held  out  NUM_CH  high while Stable[i] has been 1 for ≥HOLD_CYCLES cycles.

Behaviour:
- Reset_n low (async): sync flops, counters, Stable, Rise, Fall and Held all go to 0 immediately. Release is synchronous to the next clk edge.
- Synchronizer: two flops per channel (s1, s2); s2 is the sampled value. Raw edge to s2 takes 2 cycles.
- Debounce state per channel is {Stable, deb_cnt}. deb_cnt is ceil(log2(DEBOUNCE_CYCLES)) bits.
  - s2 == Stable: deb_cnt <= 0.
  - s2 != Stable and deb_cnt < DEBOUNCE_CYCLES-1: deb_cnt <= deb_cnt+1.
  - s2 != Stable and deb_cnt == DEBOUNCE_CYCLES-1: Stable <= s2 and deb_cnt <= 0.
- Latency: a clean raw edge sampled at edge t shows on Stable at edge t+2+DEBOUNCE_CYCLES. Any bounce that returns s2 to Stable restarts the count from 0.
- Rise/Fall are registered. They assert in the same cycle Stable changes and deassert the next cycle. Never both in one cycle; never back-to-back on the same channel (minimum spacing DEBOUNCE_CYCLES).
- Hold counter per channel: ceil(log2(HOLD_CYCLES+1)) bits.
  - Cleared while Stable is 0.
  - Increments while Stable is 1, saturating at HOLD_CYCLES.
  - Held = (hold_cnt == HOLD_CYCLES), registered.
  - Held drops in the same cycle Fall asserts.
- Channels are fully independent; simultaneous activity on all channels is legal and each behaves as if alone.
- Raw input already high at reset release: Stable rises after 2+DEBOUNCE_CYCLES cycles with a Rise pulse. This is a genuine event.
- Reset asserted mid-debounce or mid-hold: all progress is discarded and no pulse is emitted.
- Counters never wrap; the debounce counter cannot exceed DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package tlc_pkg holds:
  - Default constants: DEBOUNCE_CYCLES_DEF, HOLD_CYCLES_DEF, NUM_CH_DEF.
  - Channel index constants: CH_SENSOR=0, CH_WALK=1, CH_REPROG=2, CH_SPARE=3.
  - A clog2-based width helper function.
- Sub-module debounce_channel holds the single-channel sync, debounce, edge and hold logic. input_conditioner instantiates it NUM_CH times in a generate loop.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32 and clk period 10 ns.)
1. Clean press: Raw_In[1] 0→1 sampled at edge 10 → Stable[1]=1 and Rise[1]=1 at edge 20, Rise[1]=0 at edge 21. Other channels stay 0.
2. Bounce: Raw_In[0] toggles 1,0,1,0 every 3 cycles, then holds 1 → exactly one Rise[0], arriving 10 cycles after the final 0→1. Stable[0] never glitches.
3. Long press: Raw_In[2] held high → Held[2]=1 exactly 32 cycles after Stable[2] rose. On release, Held[2] and Stable[2] drop together with Fall[2]=1 for one cycle.
4. Short glitch: 5-cycle high pulse on Raw_In[3] → Stable, Rise, Fall and Held on channel 3 stay 0 throughout.
5. Async reset mid-hold: Reset_n pulsed low for 3 ns between edges while Stable[0]=1 and hold_cnt=20 → all outputs 0 immediately with no Fall pulse. With Raw_In[0] still high, Rise[0] appears 10 cycles after release.
6. All channels: Raw_In 0000→1111 in one cycle → Rise=1111 in a single cycle. Releasing channels one cycle apart → Fall pulses staggered by one cycle each.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the traffic light controller front end: default sizing,
// channel indices and the counter-width helper used by the conditioning logic.
package tlc_pkg;

    localparam int NUM_CH_DEF          = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int HOLD_CYCLES_DEF     = 200000000;

    localparam int CH_SENSOR = 0;
    localparam int CH_WALK   = 1;
    localparam int CH_REPROG = 2;
    localparam int CH_SPARE  = 3;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw button/switch inputs and the conditioned per-channel outputs, bundled.
// master drives Raw_In and observes the results; slave is the conditioner.
interface input_conditioner_if #(
    parameter int NUM_CH = 4
);

    logic [NUM_CH-1:0] Raw_In;
    logic [NUM_CH-1:0] Stable;
    logic [NUM_CH-1:0] Rise;
    logic [NUM_CH-1:0] Fall;
    logic [NUM_CH-1:0] Held;

    modport master (output Raw_In, input Stable, Rise, Fall, Held);
    modport slave  (input Raw_In, output Stable, Rise, Fall, Held);

endinterface

// File: rtl/input_conditioner_channel.sv
// One input channel: two-flop synchronizer, debounce counter, registered
// rise/fall pulses and a saturating long-press counter driving held.
module debounce_channel
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic held
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic              s1;
    logic              s2;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              stable_next;
    logic [HOLD_W-1:0] hold_next;

    // hold_cnt counts cycles already spent high, so it reads 0 on the rising edge
    // and held tracks the next-state level so it falls together with fall.
    always_comb begin
        accept      = (s2 != stable) && (deb_cnt == DEB_LAST);
        stable_next = accept ? s2 : stable;
        hold_next   = hold_cnt;
        if (!stable) begin
            hold_next = '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_next = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            deb_cnt  <= '0;
            stable   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            hold_cnt <= '0;
            held     <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if ((s2 == stable) || accept) begin
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            stable   <= stable_next;
            rise     <= accept & s2;
            fall     <= accept & ~s2;
            hold_cnt <= hold_next;
            held     <= stable_next && (hold_next == HOLD_MAX);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions NUM_CH raw asynchronous inputs into clean levels, edge pulses and
// long-press flags; channels are fully independent copies of debounce_channel.
module input_conditioner
    import tlc_pkg::*;
#(
    parameter int NUM_CH          = NUM_CH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input logic                clk,
    input logic                Reset_n,
    input_conditioner_if.slave bus
);

    logic [NUM_CH-1:0] stable_v;
    logic [NUM_CH-1:0] rise_v;
    logic [NUM_CH-1:0] fall_v;
    logic [NUM_CH-1:0] held_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (Reset_n),
            .raw    (bus.Raw_In[i]),
            .stable (stable_v[i]),
            .rise   (rise_v[i]),
            .fall   (fall_v[i]),
            .held   (held_v[i])
        );
    end

    assign bus.Stable = stable_v;
    assign bus.Rise   = rise_v;
    assign bus.Fall   = fall_v;
    assign bus.Held   = held_v;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32: directed
// scenarios with literal expectations plus randomized activity against a window model.
module tb_input_conditioner;
    import tlc_pkg::*;

    localparam int NCH  = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 32;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    input_conditioner_if #(.NUM_CH(NCH)) bus ();

    input_conditioner #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples are delayed two edges; a level is accepted once the last DEB
    // delayed samples all disagree with the current level.
    logic [NCH-1:0]   samp_q[$];
    logic [NCH-1:0]   win_q[$];
    logic [4*NCH-1:0] exp_q[$];
    logic [NCH-1:0]   m_stable, m_rise, m_fall, m_held;
    int               edge_n;
    int               rise_at[NCH];

    task automatic model_reset();
        samp_q.delete();
        samp_q.push_back('0);
        samp_q.push_back('0);
        win_q.delete();
        exp_q.delete();
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_held   = '0;
        edge_n   = 0;
        for (int c = 0; c < NCH; c++) rise_at[c] = 0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] s2v;
        logic [NCH-1:0] prev;
        bit             all_diff;
        s2v = samp_q.pop_front();
        samp_q.push_back(bus.Raw_In);
        win_q.push_back(s2v);
        if (win_q.size() > DEB) void'(win_q.pop_front());
        prev = m_stable;
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            if (win_q.size() == DEB) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][c] == m_stable[c]) all_diff = 1'b0;
                if (all_diff) m_stable[c] = ~m_stable[c];
            end
        end
        m_rise = m_stable & ~prev;
        m_fall = prev & ~m_stable;
        for (int c = 0; c < NCH; c++) begin
            if (m_rise[c]) rise_at[c] = edge_n;
            m_held[c] = m_stable[c] && ((edge_n - rise_at[c]) >= HOLD);
        end
        exp_q.push_back({m_stable, m_rise, m_fall, m_held});
    endtask

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) model_reset();
        else          model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : cmp_p
        logic [4*NCH-1:0] act;
        logic [4*NCH-1:0] exp;
        act = {bus.Stable, bus.Rise, bus.Fall, bus.Held};
        if (!Reset_n) begin
            check("reset_outputs", 64'(act), 64'd0);
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("model_cycle", 64'(act), 64'(exp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [NCH-1:0] v);
        bus.Raw_In = v;
    endtask

    // ---------------- stimulus ----------------
    int rises;
    int rise_k;
    bit glitch;
    logic [3:0] acc;
    int run_len[NCH];

    initial begin
        drive('0);
        tick(3);
        check("reset_state", 64'({bus.Stable, bus.Rise, bus.Fall, bus.Held}), 64'd0);
        Reset_n = 1'b1;
        tick(4);

        // clean press on the walk channel
        bus.Raw_In[CH_WALK] = 1'b1;
        tick(9);
        check("t1_before_accept", 64'(bus.Stable), 64'd0);
        tick(1);
        check("t1_stable", 64'(bus.Stable), 64'b0010);
        check("t1_rise", 64'(bus.Rise), 64'b0010);
        tick(1);
        check("t1_rise_drop", 64'(bus.Rise), 64'd0);
        bus.Raw_In[CH_WALK] = 1'b0;
        tick(14);

        // bouncing sensor input
        rises = 0; rise_k = -1; glitch = 1'b0;
        for (int p = 0; p < 4; p++) begin
            bus.Raw_In[CH_SENSOR] = (p % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (bus.Rise[CH_SENSOR]) rises++;
                if (bus.Stable[CH_SENSOR]) glitch = 1'b1;
            end
        end
        bus.Raw_In[CH_SENSOR] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (bus.Rise[CH_SENSOR]) begin
                rises++;
                rise_k = k;
            end
            if (bus.Stable[CH_SENSOR] != (k >= 10)) glitch = 1'b1;
        end
        check("t2_rise_count", 64'(rises), 64'd1);
        check("t2_rise_cycle", 64'(rise_k), 64'd10);
        check("t2_no_glitch", 64'(glitch), 64'd0);
        bus.Raw_In[CH_SENSOR] = 1'b0;
        tick(14);

        // long press on the reprogram channel
        bus.Raw_In[CH_REPROG] = 1'b1;
        tick(10);
        check("t3_stable", 64'(bus.Stable), 64'b0100);
        tick(31);
        check("t3_held_early", 64'(bus.Held[CH_REPROG]), 64'd0);
        tick(1);
        check("t3_held", 64'(bus.Held[CH_REPROG]), 64'd1);
        tick(5);
        bus.Raw_In[CH_REPROG] = 1'b0;
        tick(9);
        check("t3_held_before_release", 64'({bus.Stable[CH_REPROG], bus.Held[CH_REPROG]}), 64'b11);
        tick(1);
        check("t3_release", 64'({bus.Stable[CH_REPROG], bus.Held[CH_REPROG], bus.Fall[CH_REPROG]}), 64'b001);
        tick(1);
        check("t3_fall_drop", 64'(bus.Fall), 64'd0);
        tick(3);

        // short glitch on the spare channel
        acc = '0;
        bus.Raw_In[CH_SPARE] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) bus.Raw_In[CH_SPARE] = 1'b0;
            tick(1);
            acc |= {bus.Stable[CH_SPARE], bus.Rise[CH_SPARE], bus.Fall[CH_SPARE], bus.Held[CH_SPARE]};
        end
        check("t4_glitch_ignored", 64'(acc), 64'd0);

        // asynchronous reset part-way through a hold
        bus.Raw_In[CH_SENSOR] = 1'b1;
        tick(10);
        check("t5_stable", 64'(bus.Stable), 64'b0001);
        tick(20);
        #1 Reset_n = 1'b0;
        #1 check("t5_async_clear", 64'({bus.Stable, bus.Rise, bus.Fall, bus.Held}), 64'd0);
        #2 Reset_n = 1'b1;
        tick(9);
        check("t5_no_early_rise", 64'({bus.Stable[CH_SENSOR], bus.Rise[CH_SENSOR]}), 64'd0);
        tick(1);
        check("t5_rise_after_reset", 64'(bus.Rise), 64'b0001);
        bus.Raw_In[CH_SENSOR] = 1'b0;
        tick(14);

        // all channels together, staggered release
        drive(4'b1111);
        tick(10);
        check("t6_rise_all", 64'(bus.Rise), 64'b1111);
        tick(2);
        drive(4'b1110); tick(1);
        drive(4'b1100); tick(1);
        drive(4'b1000); tick(1);
        drive(4'b0000); tick(7);
        check("t6_fall_ch0", 64'(bus.Fall), 64'b0001);
        tick(1);
        check("t6_fall_ch1", 64'(bus.Fall), 64'b0010);
        tick(1);
        check("t6_fall_ch2", 64'(bus.Fall), 64'b0100);
        tick(1);
        check("t6_fall_ch3", 64'(bus.Fall), 64'b1000);
        tick(3);

        // randomized activity: mixes glitches, accepted presses and long holds
        for (int c = 0; c < NCH; c++) run_len[c] = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                run_len[c]--;
                if (run_len[c] <= 0) begin
                    bus.Raw_In[c] = ~bus.Raw_In[c];
                    run_len[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60)
                                                             : $urandom_range(1, 12);
                end
            end
            tick(1);
            if (cyc == 1500) begin
                #1 Reset_n = 1'b0;
                #3 Reset_n = 1'b1;
            end
        end
        drive('0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
